// File: rtl/complex_mul_seq.sv
// Sequential complex multiplier: one shared WIDTH x WIDTH multiplier stepped
// over four product cycles, giving A*B or A*conj(B) with modulo-2^WIDTH wrap.
module complex_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             conj_B,
    input  logic [WIDTH-1:0] re_A,
    input  logic [WIDTH-1:0] im_A,
    input  logic [WIDTH-1:0] re_B,
    input  logic [WIDTH-1:0] im_B,
    output logic [WIDTH-1:0] re_C,
    output logic [WIDTH-1:0] im_C,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M0   = 3'd1,
        M1   = 3'd2,
        M2   = 3'd3,
        M3   = 3'd4
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_re_a, r_im_a, r_re_b, r_im_b;
    logic             r_conj;
    logic [WIDTH-1:0] r_acc_re, r_acc_im;
    logic [WIDTH-1:0] r_re_c, r_im_c;
    logic             r_busy, r_done;

    logic [WIDTH-1:0] w_mul_a, w_mul_b, w_prod, w_addend;
    logic [WIDTH-1:0] w_acc_re_nxt, w_acc_im_nxt;
    logic             w_sub;

    // Operand select for the single shared multiplier, one product per state.
    always_comb begin
        w_mul_a = r_re_a;
        w_mul_b = r_re_b;
        w_sub   = 1'b0;
        case (r_state)
            M1: begin
                w_mul_a = r_im_a;
                w_mul_b = r_im_b;
                w_sub   = ~r_conj;
            end
            M2: begin
                w_mul_a = r_im_a;
                w_mul_b = r_re_b;
            end
            M3: begin
                w_mul_a = r_re_a;
                w_mul_b = r_im_b;
                w_sub   = r_conj;
            end
            default: ;
        endcase
    end

    // Low WIDTH bits of a product are identical for signed and unsigned operands.
    assign w_prod       = w_mul_a * w_mul_b;
    assign w_addend     = w_sub ? (~w_prod + 1'b1) : w_prod;
    assign w_acc_re_nxt = r_acc_re + w_addend;
    assign w_acc_im_nxt = r_acc_im + w_addend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_re_a   <= '0;
            r_im_a   <= '0;
            r_re_b   <= '0;
            r_im_b   <= '0;
            r_conj   <= 1'b0;
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_re_c   <= '0;
            r_im_c   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_re_a   <= re_A;
                        r_im_a   <= im_A;
                        r_re_b   <= re_B;
                        r_im_b   <= im_B;
                        r_conj   <= conj_B;
                        r_acc_re <= '0;
                        r_acc_im <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= M0;
                    end
                end
                M0: begin
                    r_acc_re <= w_acc_re_nxt;
                    r_state  <= M1;
                end
                M1: begin
                    r_acc_re <= w_acc_re_nxt;
                    r_state  <= M2;
                end
                M2: begin
                    r_acc_im <= w_acc_im_nxt;
                    r_state  <= M3;
                end
                M3: begin
                    r_acc_im <= w_acc_im_nxt;
                    r_re_c   <= r_acc_re;
                    r_im_c   <= w_acc_im_nxt;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign re_C = r_re_c;
    assign im_C = r_im_c;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_complex_mul_seq.sv
// Randomised and directed bench for complex_mul_seq against a plain-arithmetic
// complex product model.
module tb_complex_mul_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n, start, conj_B;
    logic [W-1:0] re_A, im_A, re_B, im_B;
    logic [W-1:0] re_C, im_C;
    logic         busy, done;

    int n_pass  = 0;
    int n_total = 0;

    complex_mul_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .conj_B(conj_B),
        .re_A(re_A), .im_A(im_A), .re_B(re_B), .im_B(im_B),
        .re_C(re_C), .im_C(im_C), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1);
    end

    // Reference: complex product with wide integer arithmetic, then wrap to W bits.
    function automatic void cmul(input logic [W-1:0] ar, ai, br, bi, input logic cj,
                                 output logic [W-1:0] er, output logic [W-1:0] ei);
        longint a_r, a_i, b_r, b_i, s, r, i;
        a_r = longint'($signed(ar));
        a_i = longint'($signed(ai));
        b_r = longint'($signed(br));
        b_i = longint'($signed(bi));
        s   = cj ? -1 : 1;
        r   = a_r * b_r - s * a_i * b_i;
        i   = s * a_r * b_i + a_i * b_r;
        er  = r[W-1:0];
        ei  = i[W-1:0];
    endfunction

    task automatic scramble();
        re_A   = W'($urandom);
        im_A   = W'($urandom);
        re_B   = W'($urandom);
        im_B   = W'($urandom);
        conj_B = 1'($urandom);
    endtask

    // Called at posedge+1 with the block idle; returns at posedge+1 of the done cycle.
    task automatic run_op(input logic [W-1:0] ar, ai, br, bi, input logic cj, input string nm);
        logic [W-1:0] er, ei;
        int cnt;
        cmul(ar, ai, br, bi, cj, er, ei);
        re_A = ar; im_A = ai; re_B = br; im_B = bi; conj_B = cj;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        while (!done && cnt < 10) begin
            n_total++;
            if (busy !== 1'b1) $display("FAIL %s busy_in_op: got %b want 1 (cycle %0d)", nm, busy, cnt);
            else n_pass++;
            scramble();
            @(posedge clk); #1;
            cnt++;
        end
        n_total++;
        if (cnt !== 4) $display("FAIL %s latency: got %0d want 4", nm, cnt);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL %s busy_with_done: got %b want 0", nm, busy);
        else n_pass++;
        n_total++;
        if (re_C !== er) $display("FAIL %s re_C: got %h want %h", nm, re_C, er);
        else n_pass++;
        n_total++;
        if (im_C !== ei) $display("FAIL %s im_C: got %h want %h", nm, im_C, ei);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; scramble();
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({re_C, im_C} !== '0) $display("FAIL reset_out: got %h_%h want 0_0", re_C, im_C);
        else n_pass++;
        n_total++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_flags: got busy=%b done=%b want 0 0", busy, done);
        else n_pass++;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] v;
        run_op(16'd3, 16'd4, 16'd1, 16'd2, 1'b0, "plain");
        n_total++;
        if (re_C !== 16'hFFFB) $display("FAIL plain_const re_C: got %h want fffb", re_C);
        else n_pass++;
        run_op(16'd3, 16'd4, 16'd1, 16'd2, 1'b1, "conj");
        n_total++;
        if ({re_C, im_C} !== 32'h000B_FFFE) $display("FAIL conj_const: got %h_%h want 000b_fffe", re_C, im_C);
        else n_pass++;
        run_op(16'd256, 16'd0, 16'd256, 16'd0, 1'b0, "wrap256");
        v = 16'hFFFF;
        run_op(v, v, v, 16'd1, 1'b0, "neg_ones");
        n_total++;
        if ({re_C, im_C} !== 32'h0002_0000) $display("FAIL neg_ones_const: got %h_%h want 0002_0000", re_C, im_C);
        else n_pass++;
    endtask

    task automatic test_hold();
        logic [W-1:0] hr, hi;
        hr = re_C; hi = im_C;
        for (int i = 0; i < 4; i++) begin
            start = 1'b0; scramble();
            @(posedge clk); #1;
        end
        n_total++;
        if ({re_C, im_C} !== {hr, hi}) $display("FAIL hold_out: got %h_%h want %h_%h", re_C, im_C, hr, hi);
        else n_pass++;
        n_total++;
        if (done !== 1'b0) $display("FAIL hold_done: got %b want 0", done);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            run_op(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'($urandom), "random");
            // gap 0 exercises back-to-back acceptance in the done cycle
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Start held for 10 edges; model: a request is taken whenever the block is free,
    // and then occupies it for 5 edges with its result appearing after 4.
    task automatic test_busy_guard();
        logic [W-1:0] er[$], ei[$];
        int due[$];
        int free_at, ndone, first_done, last_done;
        logic [W-1:0] xr, xi;
        free_at = 0; ndone = 0; first_done = -1; last_done = -1;
        for (int e = 0; e < 16; e++) begin
            scramble();
            start = (e < 10);
            if (start && e >= free_at) begin
                cmul(re_A, im_A, re_B, im_B, conj_B, xr, xi);
                er.push_back(xr); ei.push_back(xi); due.push_back(e + 4);
                free_at = e + 5;
            end
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = e;
                last_done = e;
            end
            if (due.size() > 0 && due[0] == e) begin
                n_total++;
                if (done !== 1'b1) $display("FAIL guard_done_due: got %b want 1 at edge %0d", done, e);
                else n_pass++;
                n_total++;
                if ({re_C, im_C} !== {er[0], ei[0]})
                    $display("FAIL guard_result: got %h_%h want %h_%h", re_C, im_C, er[0], ei[0]);
                else n_pass++;
                void'(er.pop_front()); void'(ei.pop_front()); void'(due.pop_front());
            end
        end
        start = 1'b0;
        n_total++;
        if (ndone !== 2) $display("FAIL guard_pulses: got %0d want 2", ndone);
        else n_pass++;
        n_total++;
        if (last_done - first_done !== 5) $display("FAIL guard_spacing: got %0d want 5", last_done - first_done);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen;
        run_op(16'd3, 16'd4, 16'd1, 16'd2, 1'b0, "pre_reset");
        re_A = 16'd7; im_A = 16'd5; re_B = 16'd2; im_B = 16'd9; conj_B = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({re_C, im_C} !== '0) $display("FAIL midreset_out: got %h_%h want 0_0", re_C, im_C);
        else n_pass++;
        n_total++;
        if ({busy, done} !== 2'b00) $display("FAIL midreset_flags: got busy=%b done=%b want 0 0", busy, done);
        else n_pass++;
        @(posedge clk); #3;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        n_total++;
        if (seen !== 0) $display("FAIL midreset_no_done: got %0d pulses want 0", seen);
        else n_pass++;
        run_op(16'd7, 16'd5, 16'd2, 16'd9, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_random();
        test_busy_guard();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
